hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core (IF, ID, EXE, MEM, WB).
- Generates per-stage enables and flushes for the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB registers.
- Handles load-use stalls, taken-branch flushes, and a request/acknowledge handshake to a variable-latency data memory.
- Sits beside the datapath and drives the enable/flush inputs of every stage register.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles spent in MEM_WAIT before timeout_err is raised; valid range 1..65535.
- CNT_W, 16: width of the internal wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_inst  in  32  instruction in ID.
- exe_inst  in  32  instruction in EXE.
- exe_RegDst  in  1  EXE destination select: 1 selects rd[15:11], 0 selects rt[20:16].
- exe_MemRead  in  1  EXE instruction is a load.
- exe_RegWrite  in  1  EXE instruction writes the register file.
- exe_br_taken  in  1  branch resolved taken in EXE.
- mem_MemRead  in  1  MEM-stage load.
- mem_MemWrite  in  1  MEM-stage store.
- dmem_ack  in  1  data memory completes the current access this cycle.
- pc_en  out  1  PC update enable.
- pc_sel_br  out  1  select branch target for the PC.
- if_id_en  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clear.
- id_exe_en  out  1  ID/EXE load enable.
- id_exe_flush  out  1  ID/EXE clear (bubble insert).
- exe_mem_en  out  1  EXE/MEM load enable.
- mem_wb_flush  out  1  MEM/WB clear.
- dmem_req  out  1  data memory request.
- timeout_err  out  1  sticky memory-timeout flag.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset (clk edge with rst=1): state goes to RUN, wait counter to 0, timeout_err to 0. A reset asserted mid-operation, including during MEM_WAIT, abandons the access.
- While rst=1, all outputs are 0 except state_o=RUN.
- State encoding: RUN=0, MEM_WAIT=1, BR_FLUSH=2.
- Hazard decode (combinational):
  - exe_dst = exe_RegDst ? exe_inst[15:11] : exe_inst[20:16].
  - id_rs = id_inst[25:21]; id_rt = id_inst[20:16].
  - uses_rt = 1 when opcode id_inst[31:26] is 0x00, 0x04, 0x05 or 0x2B.
  - load_use = exe_MemRead & exe_RegWrite & (exe_dst != 0) & ((exe_dst == id_rs) | (uses_rt & exe_dst == id_rt)).
  - mem_access = mem_MemRead | mem_MemWrite.
- Priority within a cycle: memory wait, then branch, then load-use.
- RUN:
  - Defaults: all enables 1, all flushes 0, pc_sel_br=0.
  - mem_access & !dmem_ack: dmem_req=1; pc_en, if_id_en, id_exe_en, exe_mem_en all 0; mem_wb_flush=1; next state MEM_WAIT; counter reset to 1.
  - mem_access & dmem_ack: dmem_req=1, no stall (zero-wait access).
  - Otherwise, exe_br_taken: pc_sel_br=1, if_id_flush=1, id_exe_flush=1; next state BR_FLUSH. Branch overrides load_use because the ID instruction is wrong-path.
  - Otherwise, load_use: pc_en=0, if_id_en=0, id_exe_flush=1; stays in RUN; exactly one bubble per load-use pair.
- MEM_WAIT:
  - dmem_req held at 1; pipeline frozen as on entry; mem_wb_flush=1; counter increments each cycle.
  - dmem_ack=1: that cycle behaves as RUN with the access complete. All enables 1, mem_wb_flush=0, branch/load-use rules apply. Next state RUN, or BR_FLUSH if exe_br_taken.
  - Counter reaching MEM_TIMEOUT with no ack: timeout_err set (sticky until rst). Stay in MEM_WAIT; the counter saturates.
- BR_FLUSH:
  - One cycle: if_id_flush=1, all enables 1, pc_sel_br=0, so the fetch from the target proceeds.
  - Next state RUN.
  - A memory access in this cycle follows the RUN memory rules and takes priority.
- dmem_req is combinational from state and inputs; there are no registered outputs other than timeout_err and state_o.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds output ports stall_cycles[31:0] and flush_events[31:0], both cleared by rst.
  - stall_cycles increments every cycle pc_en=0 outside reset.
  - flush_events increments on each entry to BR_FLUSH.
  - Both counters wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: exe lw $8 (exe_MemRead=1, RegWrite=1, RegDst=0, rt=8); id add with rs=8 -> one cycle of pc_en=0, if_id_en=0, id_exe_flush=1; next cycle all enables 1.
- No false stall: same load with exe_dst=0, or id lui (opcode 0x0F) with rt=8 -> pc_en=1, id_exe_flush=0.
- Memory wait: mem_MemRead=1, dmem_ack low 3 cycles, then high -> dmem_req=1 for 4 cycles; exe_mem_en=0 and mem_wb_flush=1 for 3 cycles; state_o 1,1,1 then 0.
- Branch overriding load-use: exe_br_taken=1 with load_use=1 -> pc_sel_br=1, if_id_flush=1, id_exe_flush=1 in cycle 0; cycle 1 state_o=2, if_id_flush=1; cycle 2 state_o=0.
- Timeout: MEM_TIMEOUT=4, dmem_ack never asserted -> timeout_err rises on the 4th MEM_WAIT cycle and stays high; rst=1 -> timeout_err=0, state_o=0 after the next edge.
- Reset mid-wait: rst asserted during MEM_WAIT -> next edge state_o=0, dmem_req=0; with HAZARD_PERF_CNT_EN defined, stall_cycles=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline sequencing controller for the 5-stage core (IF, ID, EXE, MEM, WB).
//   It drives the enable/flush inputs of every stage register. It handles three
//   kinds of event: load-use stalls, taken-branch flushes, and the req/ack
//   handshake to a variable-latency data memory.
//   If several events occur in one cycle, the memory wait wins, then the
//   branch, then the load-use stall.
//
// Parameters
//   MEM_TIMEOUT : cycles allowed in MEM_WAIT before timeout_err (1..65535)
//   CNT_W       : width of the wait counter (must hold MEM_TIMEOUT)
//
// Ports
//   clk, rst                       clock (rising edge), synchronous active-high reset
//   id_inst, exe_inst              instruction words held in ID and EXE
//   exe_RegDst/MemRead/RegWrite    EXE control bits used by the load-use check
//   exe_br_taken                   branch resolved taken in EXE
//   mem_MemRead/MemWrite           MEM-stage access request
//   dmem_ack                       data memory completes the access this cycle
//   pc_en, pc_sel_br               PC enable and branch-target select
//   if_id_en/flush, id_exe_en/flush, exe_mem_en, mem_wb_flush
//                                  stage-register controls
//   dmem_req                       data memory request
//   timeout_err                    sticky memory-timeout flag
//   state_o                        FSM state for debug (RUN=0, MEM_WAIT=1, BR_FLUSH=2)
//
// Optional feature (macro HAZARD_PERF_CNT_EN)
//   When defined, adds the wrapping 32-bit counters stall_cycles and
//   flush_events.
//   stall_cycles counts cycles with pc_en=0.
//   flush_events counts entries into BR_FLUSH.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] id_inst,
    input  logic [31:0] exe_inst,
    input  logic        exe_RegDst,
    input  logic        exe_MemRead,
    input  logic        exe_RegWrite,
    input  logic        exe_br_taken,
    input  logic        mem_MemRead,
    input  logic        mem_MemWrite,
    input  logic        dmem_ack,
    output logic        pc_en,
    output logic        pc_sel_br,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_exe_en,
    output logic        id_exe_flush,
    output logic        exe_mem_en,
    output logic        mem_wb_flush,
    output logic        dmem_req,
    output logic        timeout_err,
    output logic [1:0]  state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_FLUSH = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    // ---------------- hazard decode ----------------
    logic [4:0] exe_dst, id_rs, id_rt;
    logic       uses_rt, load_use, mem_access, mem_freeze;

    assign exe_dst    = exe_RegDst ? exe_inst[15:11] : exe_inst[20:16];
    assign id_rs      = id_inst[25:21];
    assign id_rt      = id_inst[20:16];
    assign mem_access = mem_MemRead | mem_MemWrite;

    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first; a path that leaves it unassigned would infer a latch.
        uses_rt = 1'b0;
        case (id_inst[31:26])
            6'h00, 6'h04, 6'h05, 6'h2B: uses_rt = 1'b1;  // R-type, beq, bne, sw
            default:                    uses_rt = 1'b0;
        endcase
    end

    assign load_use = exe_MemRead & exe_RegWrite & (exe_dst != 5'd0) &
                      ((exe_dst == id_rs) | (uses_rt & (exe_dst == id_rt)));

    // The pipeline freezes whenever an access is outstanding and not acked.
    // This holds in MEM_WAIT, or in any other state once MEM requests.
    assign mem_freeze = ~dmem_ack & ((state_q == MEM_WAIT) | mem_access);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MEM_WAIT: begin
                if (dmem_ack) begin
                    state_d = exe_br_taken ? BR_FLUSH : RUN;
                    cnt_d   = '0;
                end else if (cnt_q < TIMEOUT) begin
                    cnt_d   = cnt_q + 1'b1;   // saturates at TIMEOUT
                end
            end
            default: begin  // RUN, BR_FLUSH (and the unused encoding)
                if (mem_access && !dmem_ack) begin
                    state_d = MEM_WAIT;
                    cnt_d   = CNT_W'(1);
                end else if (state_q == RUN && exe_br_taken) begin
                    state_d = BR_FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
        endcase
        // The flag is registered, so it is raised on the edge where the
        // counter reaches the limit. It is then visible in that MEM_WAIT cycle.
        err_d = err_q | ((state_d == MEM_WAIT) && (cnt_d == TIMEOUT));
    end

    // ---------------- output logic ----------------
    always_comb begin
        pc_en        = 1'b1;
        pc_sel_br    = 1'b0;
        if_id_en     = 1'b1;
        if_id_flush  = 1'b0;
        id_exe_en    = 1'b1;
        id_exe_flush = 1'b0;
        exe_mem_en   = 1'b1;
        mem_wb_flush = 1'b0;
        dmem_req     = (state_q == MEM_WAIT) | mem_access;
        timeout_err  = err_q;

        if (mem_freeze) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_exe_en    = 1'b0;
            exe_mem_en   = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (state_q == BR_FLUSH) begin
            // EXE holds the bubble inserted by the branch, so branch and
            // load-use inputs are ignored. Only the second wrong-path slot
            // is flushed.
            if_id_flush  = 1'b1;
        end else if (exe_br_taken) begin
            // The ID instruction is on the wrong path, so the branch
            // overrides any load-use stall it would cause.
            pc_sel_br    = 1'b1;
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else if (load_use) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_exe_flush = 1'b1;
        end

        if (rst) begin
            pc_en        = 1'b0;
            pc_sel_br    = 1'b0;
            if_id_en     = 1'b0;
            if_id_flush  = 1'b0;
            id_exe_en    = 1'b0;
            id_exe_flush = 1'b0;
            exe_mem_en   = 1'b0;
            mem_wb_flush = 1'b0;
            dmem_req     = 1'b0;
            timeout_err  = 1'b0;
        end
    end

    assign state_o = rst ? RUN : state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, ~pc_en};
        flush_events_d = flush_events_q +
                         {31'd0, (state_d == BR_FLUSH) && (state_q != BR_FLUSH)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl (MEM_TIMEOUT=4).
//   Each step drives the inputs at a falling edge and pushes the expected
//   output vector to a scoreboard queue. It then captures the DUT outputs two
//   time units later, before the rising edge.
//   Each test task drains the queues at its end and compares them entry by
//   entry.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_ctrl;

    typedef struct packed {
        logic [7:0] ctl;   // pc_en sel if_en if_fl idex_en idex_fl exmem_en memwb_fl
        logic       req;
        logic       err;
        logic [1:0] st;
    } vec_t;

    // ctl patterns: pc_en,pc_sel_br,if_id_en,if_id_flush,id_exe_en,id_exe_flush,exe_mem_en,mem_wb_flush
    localparam logic [7:0] C_RUN = 8'b1_0_1_0_1_0_1_0;
    localparam logic [7:0] C_LU  = 8'b0_0_0_0_1_1_1_0;
    localparam logic [7:0] C_FRZ = 8'b0_0_0_0_0_0_0_1;
    localparam logic [7:0] C_BR  = 8'b1_1_1_1_1_1_1_0;
    localparam logic [7:0] C_BRF = 8'b1_0_1_1_1_0_1_0;
    localparam logic [7:0] C_RST = 8'b0_0_0_0_0_0_0_0;

    localparam logic [31:0] LW8     = {6'h23, 5'd1, 5'd8, 16'h0010};
    localparam logic [31:0] LW9     = {6'h23, 5'd1, 5'd9, 16'h0010};
    localparam logic [31:0] LW0     = {6'h23, 5'd1, 5'd0, 16'h0010};
    localparam logic [31:0] R_RD8   = {6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h20};
    localparam logic [31:0] ADD_RS8 = {6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20};
    localparam logic [31:0] ADD_RS9 = {6'h00, 5'd9, 5'd3, 5'd11, 5'd0, 6'h20};
    localparam logic [31:0] ADD_RT8 = {6'h00, 5'd3, 5'd8, 5'd10, 5'd0, 6'h20};
    localparam logic [31:0] ADD_R0  = {6'h00, 5'd0, 5'd0, 5'd10, 5'd0, 6'h20};
    localparam logic [31:0] SW_RT8  = {6'h2B, 5'd3, 5'd8, 16'h0004};
    localparam logic [31:0] BEQ_RT8 = {6'h04, 5'd3, 5'd8, 16'h0004};
    localparam logic [31:0] LUI_RT8 = {6'h0F, 5'd0, 5'd8, 16'h1234};
    localparam logic [31:0] ADDI8   = {6'h08, 5'd3, 5'd8, 16'h0001};
    localparam logic [31:0] NOP     = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] id_inst = '0, exe_inst = '0;
    logic        exe_RegDst = 1'b0, exe_MemRead = 1'b0, exe_RegWrite = 1'b0;
    logic        exe_br_taken = 1'b0, mem_MemRead = 1'b0, mem_MemWrite = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        pc_en, pc_sel_br, if_id_en, if_id_flush, id_exe_en, id_exe_flush;
    logic        exe_mem_en, mem_wb_flush, dmem_req, timeout_err;
    logic [1:0]  state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int total = 0;
    int bad   = 0;

    vec_t  exp_q[$];
    vec_t  got_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_inst      (id_inst),
        .exe_inst     (exe_inst),
        .exe_RegDst   (exe_RegDst),
        .exe_MemRead  (exe_MemRead),
        .exe_RegWrite (exe_RegWrite),
        .exe_br_taken (exe_br_taken),
        .mem_MemRead  (mem_MemRead),
        .mem_MemWrite (mem_MemWrite),
        .dmem_ack     (dmem_ack),
        .pc_en        (pc_en),
        .pc_sel_br    (pc_sel_br),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_exe_en    (id_exe_en),
        .id_exe_flush (id_exe_flush),
        .exe_mem_en   (exe_mem_en),
        .mem_wb_flush (mem_wb_flush),
        .dmem_req     (dmem_req),
        .timeout_err  (timeout_err),
        .state_o      (state_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
`endif
    );

    function automatic vec_t observe();
        vec_t v;
        v.ctl = {pc_en, pc_sel_br, if_id_en, if_id_flush,
                 id_exe_en, id_exe_flush, exe_mem_en, mem_wb_flush};
        v.req = dmem_req;
        v.err = timeout_err;
        v.st  = state_o;
        return v;
    endfunction

    function automatic vec_t ex(input logic [7:0] ctl, input logic req,
                                input logic err, input logic [1:0] st);
        vec_t v;
        v.ctl = ctl; v.req = req; v.err = err; v.st = st;
        return v;
    endfunction

    // One clock step: drive inputs, push the expectation, capture outputs.
    // exe_ctl = {RegDst, MemRead, RegWrite}; mem_ctl = {MemRead, MemWrite, ack}.
    task automatic drive(input logic r, input logic [31:0] idi, input logic [31:0] exi,
                         input logic [2:0] exe_ctl, input logic br,
                         input logic [2:0] mem_ctl, input vec_t want, input string nm);
        @(negedge clk);
        rst          = r;
        id_inst      = idi;
        exe_inst     = exi;
        {exe_RegDst, exe_MemRead, exe_RegWrite} = exe_ctl;
        exe_br_taken = br;
        {mem_MemRead, mem_MemWrite, dmem_ack} = mem_ctl;
        exp_q.push_back(want);
        name_q.push_back(nm);
        #2;
        got_q.push_back(observe());
    endtask

    task automatic test_reset();
        drive(1, ADD_RS8, LW8, 3'b011, 1, 3'b100, ex(C_RST, 0, 0, 2'd0), "rst_hold_a");
        drive(1, ADD_RS8, LW8, 3'b011, 1, 3'b110, ex(C_RST, 0, 0, 2'd0), "rst_hold_b");
        drive(0, NOP, NOP, 3'b000, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "rst_release_idle");
        while (exp_q.size() > 0) begin
            vec_t g = got_q.pop_front(); vec_t w = exp_q.pop_front(); string n = name_q.pop_front();
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL %s: got ctl=%b req=%b err=%b st=%0d want ctl=%b req=%b err=%b st=%0d",
                         n, g.ctl, g.req, g.err, g.st, w.ctl, w.req, w.err, w.st);
            end
        end
    endtask

    task automatic test_load_use();
        drive(0, ADD_RS8, LW8,   3'b011, 0, 3'b000, ex(C_LU,  0, 0, 2'd0), "lu_rs");
        drive(0, ADD_RS8, NOP,   3'b000, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "lu_after_bubble");
        drive(0, ADD_RT8, LW8,   3'b011, 0, 3'b000, ex(C_LU,  0, 0, 2'd0), "lu_rtype_rt");
        drive(0, SW_RT8,  LW8,   3'b011, 0, 3'b000, ex(C_LU,  0, 0, 2'd0), "lu_sw_rt");
        drive(0, BEQ_RT8, LW8,   3'b011, 0, 3'b000, ex(C_LU,  0, 0, 2'd0), "lu_beq_rt");
        drive(0, ADD_RS8, R_RD8, 3'b111, 0, 3'b000, ex(C_LU,  0, 0, 2'd0), "lu_regdst_rd");
        while (exp_q.size() > 0) begin
            vec_t g = got_q.pop_front(); vec_t w = exp_q.pop_front(); string n = name_q.pop_front();
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL %s: got ctl=%b req=%b err=%b st=%0d want ctl=%b req=%b err=%b st=%0d",
                         n, g.ctl, g.req, g.err, g.st, w.ctl, w.req, w.err, w.st);
            end
        end
    endtask

    task automatic test_no_false_stall();
        drive(0, ADD_R0,  LW0,   3'b011, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "nf_dst_zero");
        drive(0, LUI_RT8, LW8,   3'b011, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "nf_lui_rt");
        drive(0, ADDI8,   LW8,   3'b011, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "nf_addi_rt");
        drive(0, ADD_RS8, LW8,   3'b010, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "nf_no_regwrite");
        drive(0, ADD_RS8, LW8,   3'b001, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "nf_not_load");
        drive(0, ADD_RS8, R_RD8, 3'b011, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "nf_regdst_rt");
        while (exp_q.size() > 0) begin
            vec_t g = got_q.pop_front(); vec_t w = exp_q.pop_front(); string n = name_q.pop_front();
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL %s: got ctl=%b req=%b err=%b st=%0d want ctl=%b req=%b err=%b st=%0d",
                         n, g.ctl, g.req, g.err, g.st, w.ctl, w.req, w.err, w.st);
            end
        end
    endtask

    task automatic test_mem_wait();
        drive(0, NOP, NOP, 3'b000, 0, 3'b100, ex(C_FRZ, 1, 0, 2'd0), "mw_c0");
        drive(0, NOP, NOP, 3'b000, 0, 3'b100, ex(C_FRZ, 1, 0, 2'd1), "mw_c1");
        drive(0, NOP, NOP, 3'b000, 0, 3'b100, ex(C_FRZ, 1, 0, 2'd1), "mw_c2");
        drive(0, NOP, NOP, 3'b000, 0, 3'b101, ex(C_RUN, 1, 0, 2'd1), "mw_ack");
        drive(0, NOP, NOP, 3'b000, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "mw_back_run");
        drive(0, NOP, NOP, 3'b000, 0, 3'b011, ex(C_RUN, 1, 0, 2'd0), "mw_zero_wait");
        drive(0, NOP, NOP, 3'b000, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "mw_zero_wait_next");
        // ack cycle honours load-use
        drive(0, NOP, NOP, 3'b000, 0, 3'b010, ex(C_FRZ, 1, 0, 2'd0), "mw_lu_c0");
        drive(0, ADD_RS8, LW8, 3'b011, 0, 3'b011, ex(C_LU, 1, 0, 2'd1), "mw_lu_ack");
        drive(0, NOP, NOP, 3'b000, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "mw_lu_next");
        while (exp_q.size() > 0) begin
            vec_t g = got_q.pop_front(); vec_t w = exp_q.pop_front(); string n = name_q.pop_front();
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL %s: got ctl=%b req=%b err=%b st=%0d want ctl=%b req=%b err=%b st=%0d",
                         n, g.ctl, g.req, g.err, g.st, w.ctl, w.req, w.err, w.st);
            end
        end
    endtask

    task automatic test_branch();
        drive(0, ADD_RS8, LW8, 3'b011, 1, 3'b000, ex(C_BR,  0, 0, 2'd0), "br_over_lu");
        drive(0, NOP,     NOP, 3'b000, 0, 3'b000, ex(C_BRF, 0, 0, 2'd2), "br_flush_cycle");
        drive(0, NOP,     NOP, 3'b000, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "br_back_run");
        // memory stall in BR_FLUSH takes priority
        drive(0, NOP, NOP, 3'b000, 1, 3'b000, ex(C_BR,  0, 0, 2'd0), "br_m_c0");
        drive(0, NOP, NOP, 3'b000, 0, 3'b010, ex(C_FRZ, 1, 0, 2'd2), "br_m_frz");
        drive(0, NOP, NOP, 3'b000, 0, 3'b011, ex(C_RUN, 1, 0, 2'd1), "br_m_ack");
        drive(0, NOP, NOP, 3'b000, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "br_m_run");
        // branch resolved on the ack cycle of a wait
        drive(0, NOP, NOP, 3'b000, 0, 3'b100, ex(C_FRZ, 1, 0, 2'd0), "br_w_c0");
        drive(0, NOP, NOP, 3'b000, 1, 3'b101, ex(C_BR,  1, 0, 2'd1), "br_w_ack");
        drive(0, NOP, NOP, 3'b000, 0, 3'b000, ex(C_BRF, 0, 0, 2'd2), "br_w_flush");
        drive(0, NOP, NOP, 3'b000, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "br_w_run");
        while (exp_q.size() > 0) begin
            vec_t g = got_q.pop_front(); vec_t w = exp_q.pop_front(); string n = name_q.pop_front();
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL %s: got ctl=%b req=%b err=%b st=%0d want ctl=%b req=%b err=%b st=%0d",
                         n, g.ctl, g.req, g.err, g.st, w.ctl, w.req, w.err, w.st);
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(0, ADD_RS8, LW8, 3'b011, 0, 3'b000, ex(C_LU,  0, 0, 2'd0), "b2b_lu1");
        drive(0, ADD_RS8, NOP, 3'b000, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "b2b_bubble1");
        drive(0, ADD_RS9, LW9, 3'b011, 0, 3'b000, ex(C_LU,  0, 0, 2'd0), "b2b_lu2");
        drive(0, ADD_RS9, NOP, 3'b000, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "b2b_bubble2");
        drive(0, NOP, NOP, 3'b000, 1, 3'b000, ex(C_BR,  0, 0, 2'd0), "b2b_br1");
        drive(0, NOP, NOP, 3'b000, 1, 3'b000, ex(C_BRF, 0, 0, 2'd2), "b2b_br_in_flush");
        drive(0, NOP, NOP, 3'b000, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "b2b_run");
        while (exp_q.size() > 0) begin
            vec_t g = got_q.pop_front(); vec_t w = exp_q.pop_front(); string n = name_q.pop_front();
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL %s: got ctl=%b req=%b err=%b st=%0d want ctl=%b req=%b err=%b st=%0d",
                         n, g.ctl, g.req, g.err, g.st, w.ctl, w.req, w.err, w.st);
            end
        end
    endtask

    task automatic test_timeout();
        drive(0, NOP, NOP, 3'b000, 0, 3'b100, ex(C_FRZ, 1, 0, 2'd0), "to_enter");
        drive(0, NOP, NOP, 3'b000, 0, 3'b100, ex(C_FRZ, 1, 0, 2'd1), "to_w1");
        drive(0, NOP, NOP, 3'b000, 0, 3'b100, ex(C_FRZ, 1, 0, 2'd1), "to_w2");
        drive(0, NOP, NOP, 3'b000, 0, 3'b100, ex(C_FRZ, 1, 0, 2'd1), "to_w3");
        drive(0, NOP, NOP, 3'b000, 0, 3'b100, ex(C_FRZ, 1, 1, 2'd1), "to_w4_raise");
        drive(0, NOP, NOP, 3'b000, 0, 3'b100, ex(C_FRZ, 1, 1, 2'd1), "to_w5_sat");
        drive(0, NOP, NOP, 3'b000, 0, 3'b100, ex(C_FRZ, 1, 1, 2'd1), "to_w6_sat");
        drive(0, NOP, NOP, 3'b000, 0, 3'b101, ex(C_RUN, 1, 1, 2'd1), "to_late_ack");
        drive(0, NOP, NOP, 3'b000, 0, 3'b000, ex(C_RUN, 0, 1, 2'd0), "to_sticky");
        drive(1, NOP, NOP, 3'b000, 0, 3'b000, ex(C_RST, 0, 0, 2'd0), "to_rst");
        drive(0, NOP, NOP, 3'b000, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "to_cleared");
        while (exp_q.size() > 0) begin
            vec_t g = got_q.pop_front(); vec_t w = exp_q.pop_front(); string n = name_q.pop_front();
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL %s: got ctl=%b req=%b err=%b st=%0d want ctl=%b req=%b err=%b st=%0d",
                         n, g.ctl, g.req, g.err, g.st, w.ctl, w.req, w.err, w.st);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        drive(0, NOP, NOP, 3'b000, 0, 3'b100, ex(C_FRZ, 1, 0, 2'd0), "rmw_enter");
        drive(0, NOP, NOP, 3'b000, 0, 3'b100, ex(C_FRZ, 1, 0, 2'd1), "rmw_wait");
        drive(1, NOP, NOP, 3'b000, 0, 3'b100, ex(C_RST, 0, 0, 2'd0), "rmw_rst");
        drive(0, NOP, NOP, 3'b000, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "rmw_after");
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if (stall_cycles !== 32'd0) begin
            bad++;
            $display("FAIL rmw_stall_cnt: got %0d want 0", stall_cycles);
        end
        drive(0, ADD_RS8, LW8, 3'b011, 1, 3'b000, ex(C_BR,  0, 0, 2'd0), "rmw_br");
        drive(0, ADD_RS8, LW8, 3'b011, 0, 3'b000, ex(C_BRF, 0, 0, 2'd2), "rmw_brf");
        drive(0, ADD_RS8, LW8, 3'b011, 0, 3'b000, ex(C_LU,  0, 0, 2'd0), "rmw_lu");
        drive(0, NOP, NOP, 3'b000, 0, 3'b000, ex(C_RUN, 0, 0, 2'd0), "rmw_idle");
        total++;
        if (stall_cycles !== 32'd1) begin
            bad++;
            $display("FAIL perf_stall_cnt: got %0d want 1", stall_cycles);
        end
        total++;
        if (flush_events !== 32'd1) begin
            bad++;
            $display("FAIL perf_flush_cnt: got %0d want 1", flush_events);
        end
`endif
        while (exp_q.size() > 0) begin
            vec_t g = got_q.pop_front(); vec_t w = exp_q.pop_front(); string n = name_q.pop_front();
            total++;
            if (g !== w) begin
                bad++;
                $display("FAIL %s: got ctl=%b req=%b err=%b st=%0d want ctl=%b req=%b err=%b st=%0d",
                         n, g.ctl, g.req, g.err, g.st, w.ctl, w.req, w.err, w.st);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_mem_wait();
        test_branch();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
